// File: rtl/ram_fifo_ctrl.sv
// Valid/ready byte FIFO built on a single-port, write-priority, read-registered RAM.
// One RAM access per cycle: writes and reads alternate when both sides want the port.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_n;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_n;
    logic [CNT_W-1:0]  count_q,  count_n;
    logic              rd_pend_q, rd_pend_n;
    logic              last_wr_q, last_wr_n;
    logic              m_valid_q, m_valid_n;
    logic [DATA_W-1:0] m_data_q,  m_data_n;

    logic full_c;
    logic wr_want_c;
    logic rd_want_c;
    logic rd_issue_c;
    logic wr_issue_c;

    // Request generation and single-port arbitration; a read wins only when the last op was a write
    always_comb begin
        full_c     = (count_q == CNT_W'(DEPTH));
        wr_want_c  = rst_n && s_valid && !full_c;
        rd_want_c  = (count_q != '0) && !rd_pend_q && (!m_valid_q || m_ready);
        rd_issue_c = rd_want_c && (!wr_want_c || last_wr_q);
        wr_issue_c = wr_want_c && !rd_issue_c;
    end

    // RAM port drive; idle cycles park the address on the read pointer
    always_comb begin
        ram_we    = wr_issue_c;
        ram_addr  = wr_issue_c ? wr_ptr_q : rd_ptr_q;
        ram_wdata = s_data;
    end

    // Next-state for pointers, occupancy, read tracking and the output register
    always_comb begin
        wr_ptr_n  = wr_ptr_q;
        rd_ptr_n  = rd_ptr_q;
        count_n   = count_q;
        last_wr_n = last_wr_q;
        m_valid_n = m_valid_q;
        m_data_n  = m_data_q;
        rd_pend_n = rd_issue_c;

        if (wr_issue_c) begin
            wr_ptr_n  = wr_ptr_q + ADDR_W'(1);
            count_n   = count_q + CNT_W'(1);
            last_wr_n = 1'b1;
        end else if (rd_issue_c) begin
            rd_ptr_n  = rd_ptr_q + ADDR_W'(1);
            count_n   = count_q - CNT_W'(1);
            last_wr_n = 1'b0;
        end

        if (rd_pend_q) begin
            m_valid_n = 1'b1;
            m_data_n  = ram_rdata;
        end else if (m_valid_q && m_ready) begin
            m_valid_n = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
            last_wr_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_n;
            rd_ptr_q  <= rd_ptr_n;
            count_q   <= count_n;
            rd_pend_q <= rd_pend_n;
            last_wr_q <= last_wr_n;
            m_valid_q <= m_valid_n;
            m_data_q  <= m_data_n;
        end
    end

    // Status and handshake outputs; the write side is held off during reset and on read cycles
    always_comb begin
        s_ready = rst_n && !full_c && !rd_issue_c;
        m_valid = m_valid_q;
        m_data  = m_data_q;
        count   = count_q;
        full    = full_c;
        empty   = (count_q == '0) && !rd_pend_q && !m_valid_q;
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: RAM model, queue scoreboard, vector table and directed corner cases.
module tb_ram_fifo_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1024;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .full(full), .empty(empty),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: write-priority, registered read on every non-write edge
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata     <= mem[ram_addr];
    end

    int total;
    int bad;
    int wr_total;
    int pops;
    logic hs_w;
    logic [DATA_W-1:0] q[$];

    typedef struct {
        logic        s_valid;
        logic [7:0]  s_data;
        logic        m_ready;
        logic        e_we;
        logic        e_srdy;
        logic [9:0]  e_addr;
        logic [10:0] e_cnt;
        logic        e_mv;
        logic [7:0]  e_md;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle scoreboard: occupancy invariants, write address sequence, in-order delivery
    task automatic monitor();
        int d;
        d = q.size() - int'(count) - int'(m_valid);
        chk("full_flag", 32'(full), 32'(count == 11'(DEPTH)));
        chk("empty_flag", 32'(empty), 32'(q.size() == 0));
        chk("occupancy", 32'((d == 0) || (d == 1)), 32'd1);
        chk("we_vs_handshake", 32'(ram_we), 32'(s_valid && s_ready));
        hs_w = s_valid && s_ready;
        if (ram_we) begin
            chk("wr_addr", 32'(ram_addr), 32'(wr_total % DEPTH));
            chk("wr_data", 32'(ram_wdata), 32'(s_data));
            wr_total++;
        end
        if (hs_w) q.push_back(s_data);
        if (m_valid && m_ready) begin
            if (q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
            else chk("pop_data", 32'(m_data), 32'(q.pop_front()));
            pops++;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        adv();
    endtask

    task automatic check_reset_vals();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        m_ready = 1'b0;
        q.delete();
        wr_total = 0;
        pops     = 0;
        hs_w     = 1'b0;
        #3;
        check_reset_vals();
        adv();
        adv();
        s_valid = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        while (1) begin
            sample();
            if (hs_w) begin
                adv();
                s_valid = 1'b0;
                break;
            end
            adv();
            n++;
            if (n > 50) begin
                chk("push_timeout", 32'd1, 32'd0);
                s_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        s_valid = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || m_valid) && n < 5000) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(n < 5000), 32'd1);
        sample();
        chk("drain_empty", 32'(empty), 32'd1);
        adv();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] md;
        logic hs;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;

        // Vector table: {s_valid, s_data, m_ready, we, s_ready, addr, count, m_valid, m_data}
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 10'd0, 11'd0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 10'd0, 11'd1, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 10'd1, 11'd0, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 10'd2, 11'd1, 1'b1, 8'h11};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'd1, 11'd2, 1'b1, 8'h11};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 10'd1, 11'd2, 1'b1, 8'h11};
        tbl[6] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 10'd3, 11'd1, 1'b0, 8'h00};
        tbl[7] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 10'd2, 11'd2, 1'b1, 8'h22};
        tbl[8] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 10'd4, 11'd1, 1'b0, 8'h00};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            s_valid = tbl[i].s_valid;
            s_data  = tbl[i].s_data;
            m_ready = tbl[i].m_ready;
            sample();
            chk($sformatf("vec%0d_we", i), 32'(ram_we), 32'(tbl[i].e_we));
            chk($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].e_srdy));
            chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
            if (tbl[i].e_mv) chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(tbl[i].e_md));
            adv();
        end
        drain();

        // Single beat latency: write edge, read-issue edge, capture edge
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'hA5;
        m_ready = 1'b1;
        sample();
        chk("a5_we", 32'(ram_we), 32'd1);
        chk("a5_addr", 32'(ram_addr), 32'd0);
        adv();
        s_valid = 1'b0;
        sample();
        chk("a5_mv_e1", 32'(m_valid), 32'd0);
        chk("a5_read_we", 32'(ram_we), 32'd0);
        chk("a5_read_addr", 32'(ram_addr), 32'd0);
        adv();
        sample();
        chk("a5_mv_e2", 32'(m_valid), 32'd0);
        adv();
        sample();
        chk("a5_mv_e3", 32'(m_valid), 32'd1);
        chk("a5_m_data", 32'(m_data), 32'hA5);
        chk("a5_not_empty", 32'(empty), 32'd0);
        adv();
        sample();
        chk("a5_empty_after_pop", 32'(empty), 32'd1);
        adv();

        // Continuous traffic from empty: ops alternate every cycle
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'h00;
        m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            sample();
            chk($sformatf("alt_we_c%0d", c), 32'(ram_we), 32'((c % 2) == 0));
            hs = hs_w;
            adv();
            if (hs) s_data = s_data + 8'd1;
        end
        drain();

        // Fill with the consumer stalled, then top up to full
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) push(8'(i));
        for (int i = 0; i < 3; i++) cycle();
        sample();
        chk("fill_count", 32'(count), 32'd1023);
        chk("fill_full", 32'(full), 32'd0);
        chk("fill_m_valid", 32'(m_valid), 32'd1);
        chk("fill_m_data", 32'(m_data), 32'h00);
        adv();
        push(8'hAB);
        sample();
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_flag_set", 32'(full), 32'd1);
        adv();
        s_valid = 1'b1;
        s_data  = 8'hCD;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("full_s_ready", 32'(s_ready), 32'd0);
            chk("full_no_write", 32'(ram_we), 32'd0);
            adv();
        end
        s_valid = 1'b0;
        drain();
        chk("fill_pops", 32'(pops), 32'(DEPTH + 1));

        // Consumer stall with data stored: no reads, output held
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h05 + 8'(i)));
        for (int i = 0; i < 3; i++) cycle();
        sample();
        md = m_data;
        chk("stall_first", 32'(md), 32'h05);
        adv();
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("stall_m_data", 32'(m_data), 32'(md));
            chk("stall_m_valid", 32'(m_valid), 32'd1);
            chk("stall_no_op", 32'(ram_we), 32'd0);
            chk("stall_count", 32'(count), 32'd4);
            adv();
        end
        drain();

        // Random traffic past the pointer wrap point
        do_reset();
        for (int c = 0; c < 30000 && pops < 2000; c++) begin
            if (!s_valid || hs_w) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = 8'($urandom);
            end
            m_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        chk("rand_pops", 32'(pops >= 2000), 32'd1);
        chk("rand_wrapped", 32'(wr_total > int'(DEPTH)), 32'd1);
        drain();

        // Asynchronous reset while a read is in flight
        do_reset();
        m_ready = 1'b0;
        push(8'h77);
        adv();
        #2;
        rst_n   = 1'b0;
        s_valid = 1'b1;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
        q.delete();
        wr_total = 0;
        pops     = 0;
        adv();
        s_valid = 1'b0;
        m_ready = 1'b1;
        rst_n   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample();
            chk("post_rst_no_stale", 32'(m_valid), 32'd0);
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
